// File: rtl/pixel_shifter.sv
// Video byte serialiser: shifts screen bytes out as pen indices at the screen-mode rate.
// Optional: define PIXEL_SHIFTER_MODE3_EN for the 4-colour mode-3 decode at the mode-0 rate.
module pixel_shifter (
  input  logic       CLK_n,
  input  logic       RESET_n,
  input  logic       LOAD,
  input  logic [7:0] VDATA,
  input  logic       DISPEN,
  input  logic       HSYNC,
  input  logic [1:0] MODE_REQ,
  output logic [3:0] CIDX,
  output logic       MODE_IS_0,
  output logic       MODE_IS_2,
  output logic       INK_SEL,
  output logic       BORDER_SEL
);

  logic [7:0] sr_q, sr_d;
  logic [1:0] mode_eff_q, mode_eff_d;
  logic [1:0] byte_mode_q, byte_mode_d;
  logic [1:0] ph_q, ph_d;
  logic       hs_q;
  logic       de_q, de_d;
  logic [1:0] ph_last;
  logic [3:0] pen;
  logic [3:0] cidx_q, cidx_d;
  logic       mode0_q, mode2_q, ink_q, border_q;

  always_comb begin
    case (byte_mode_q)
      2'd2:    ph_last = 2'd0;
      2'd1:    ph_last = 2'd1;
      default: ph_last = 2'd3;
    endcase
  end

  // Outputs are decoded from next state so a loaded byte shows its first pixel one clock after LOAD.
  always_comb begin
    sr_d        = sr_q;
    byte_mode_d = byte_mode_q;
    de_d        = de_q;
    ph_d        = ph_q;
    if (LOAD) begin
      sr_d        = VDATA;
      byte_mode_d = mode_eff_q;
      de_d        = DISPEN;
      ph_d        = 2'd0;
    end else if (ph_q == ph_last) begin
      ph_d = 2'd0;
      sr_d = {sr_q[6:0], 1'b0};
    end else begin
      ph_d = ph_q + 2'd1;
    end
    mode_eff_d = (HSYNC && !hs_q) ? MODE_REQ : mode_eff_q;
  end

  always_comb begin
    pen = 4'd0;
    case (byte_mode_d)
      2'd2: pen = {3'b000, sr_d[7]};
      2'd1: pen = {2'b00, sr_d[3], sr_d[7]};
`ifdef PIXEL_SHIFTER_MODE3_EN
      2'd3: pen = {2'b00, sr_d[3], sr_d[7]};
`else
      2'd3: pen = {sr_d[1], sr_d[5], sr_d[3], sr_d[7]};
`endif
      default: pen = {sr_d[1], sr_d[5], sr_d[3], sr_d[7]};
    endcase
    cidx_d = de_d ? pen : 4'd0;
  end

  always_ff @(posedge CLK_n) begin
    if (!RESET_n) begin
      sr_q        <= 8'd0;
      mode_eff_q  <= 2'd0;
      byte_mode_q <= 2'd0;
      ph_q        <= 2'd0;
      hs_q        <= 1'b0;
      de_q        <= 1'b0;
      cidx_q      <= 4'd0;
      mode0_q     <= 1'b1;
      mode2_q     <= 1'b0;
      ink_q       <= 1'b0;
      border_q    <= 1'b1;
    end else begin
      sr_q        <= sr_d;
      mode_eff_q  <= mode_eff_d;
      byte_mode_q <= byte_mode_d;
      ph_q        <= ph_d;
      hs_q        <= HSYNC;
      de_q        <= de_d;
      cidx_q      <= cidx_d;
      mode0_q     <= (byte_mode_d == 2'd0) || (byte_mode_d == 2'd3);
      mode2_q     <= (byte_mode_d == 2'd2);
      ink_q       <= de_d;
      border_q    <= ~de_d;
    end
  end

  assign CIDX       = cidx_q;
  assign MODE_IS_0  = mode0_q;
  assign MODE_IS_2  = mode2_q;
  assign INK_SEL    = ink_q;
  assign BORDER_SEL = border_q;

endmodule

// File: tb/tb_pixel_shifter.sv
// Scoreboard bench for pixel_shifter: reference model derives each pixel from elapsed time since LOAD.
module tb_pixel_shifter;

  logic       CLK_n = 1'b0;
  logic       RESET_n = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] VDATA = 8'd0;
  logic       DISPEN = 1'b0;
  logic       HSYNC = 1'b0;
  logic [1:0] MODE_REQ = 2'd0;
  logic [3:0] CIDX;
  logic       MODE_IS_0, MODE_IS_2, INK_SEL, BORDER_SEL;

  pixel_shifter dut (
    .CLK_n(CLK_n), .RESET_n(RESET_n), .LOAD(LOAD), .VDATA(VDATA), .DISPEN(DISPEN),
    .HSYNC(HSYNC), .MODE_REQ(MODE_REQ), .CIDX(CIDX), .MODE_IS_0(MODE_IS_0),
    .MODE_IS_2(MODE_IS_2), .INK_SEL(INK_SEL), .BORDER_SEL(BORDER_SEL)
  );

  always #5 CLK_n = ~CLK_n;

  // Expected output word: {CIDX, MODE_IS_0, MODE_IS_2, INK_SEL, BORDER_SEL}
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit stim_done = 1'b0;

  // Reference model state: the byte being shown and how many clocks have passed since it loaded.
  int       m_mode_eff, m_byte_mode, m_t;
  bit [7:0] m_data;
  bit       m_de, m_hs_prev;

  function automatic [7:0] model_out(input int bmode, input bit [7:0] data, input int t, input bit de);
    int period, shifts;
    bit [7:0] s;
    bit [3:0] pen;
    period = (bmode == 2) ? 1 : (bmode == 1) ? 2 : 4;
    shifts = t / period;
    s = (shifts >= 8) ? 8'd0 : 8'(data << shifts);
    case (bmode)
      2: pen = {3'b000, s[7]};
      1: pen = {2'b00, s[3], s[7]};
`ifdef PIXEL_SHIFTER_MODE3_EN
      3: pen = {2'b00, s[3], s[7]};
`endif
      default: pen = {s[1], s[5], s[3], s[7]};
    endcase
    if (!de) pen = 4'd0;
    return {pen, (bmode == 0 || bmode == 3), (bmode == 2), de, ~de};
  endfunction

  task automatic step(input bit rst_n, input bit ld, input bit [7:0] vd, input bit dis,
                      input bit hs, input bit [1:0] mr);
    RESET_n = rst_n; LOAD = ld; VDATA = vd; DISPEN = dis; HSYNC = hs; MODE_REQ = mr;
    @(posedge CLK_n);
    if (!rst_n) begin
      m_mode_eff = 0; m_byte_mode = 0; m_data = 8'd0; m_t = 0; m_de = 0; m_hs_prev = 0;
    end else begin
      if (ld) begin
        m_byte_mode = m_mode_eff;
        m_data = vd; m_de = dis; m_t = 0;
        $display("load vdata=%02h mode=%0d dispen=%0d t=%0t", vd, m_byte_mode, dis, $time);
      end else if (m_t < 1000) begin
        m_t++;
      end
      if (hs && !m_hs_prev) m_mode_eff = int'(mr);
      m_hs_prev = hs;
    end
    exp_q.push_back(model_out(m_byte_mode, m_data, m_t, m_de));
    @(negedge CLK_n);
  endtask

  bit [1:0] cur_req = 2'd0;
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'd0, 0, 0, cur_req);
  endtask
  task automatic commit(input bit [1:0] m);
    cur_req = m;
    step(1, 0, 8'd0, 0, 1, m);
    step(1, 0, 8'd0, 0, 0, m);
  endtask
  task automatic load(input bit [7:0] vd, input bit dis);
    step(1, 1, vd, dis, 0, cur_req);
  endtask

  // Monitor: outputs are presented every clock, compared against the oldest expectation.
  initial begin
    logic [7:0] exp_v, act_v;
    forever begin
      @(negedge CLK_n);
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {CIDX, MODE_IS_0, MODE_IS_2, INK_SEL, BORDER_SEL};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL outputs t=%0t cidx=%0d m0=%b m2=%b ink=%b bor=%b required cidx=%0d m0=%b m2=%b ink=%b bor=%b",
                   $time, act_v[7:4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, 8'd0, 0, 0, 2'd0);
    idle(6);
    // Mode 2, 0xA5
    commit(2'd2); idle(2);
    load(8'hA5, 1); idle(10);
    // Mode 1, 0x88
    commit(2'd1);
    load(8'h88, 1); idle(9);
    // Mode 0, 0x82 then 0x40
    commit(2'd0);
    load(8'h82, 1); idle(7);
    load(8'h40, 1); idle(7);
    // Pending mode without HSYNC edge stays pending
    cur_req = 2'd2; idle(3);
    load(8'hC3, 1); idle(7);
    commit(2'd2);
    load(8'h5A, 1); idle(7);
    // HSYNC edge coinciding with LOAD: that byte keeps the old mode
    cur_req = 2'd1;
    step(1, 1, 8'h96, 1, 1, 2'd1); idle(7);
    step(1, 0, 8'd0, 0, 0, 2'd1);
    load(8'h96, 1); idle(7);
    // Border byte
    load(8'hFF, 0); idle(7);
    // Mode 3 bytes and 4-clock spacing
    commit(2'd3);
    load(8'hAA, 1); idle(3);
    load(8'h55, 1); idle(3);
    load(8'hF0, 1); idle(10);
    // Reset mid-byte
    load(8'hFF, 1); idle(2);
    step(0, 0, 8'd0, 0, 0, 2'd3);
    idle(3); load(8'hFF, 1); idle(6);
    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bit ld, hs, rst_n;
      rst_n = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 5) == 0) || ($urandom_range(0, 15) == 0);
      hs = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 7) == 0) cur_req = 2'($urandom_range(0, 3));
      step(rst_n, ld, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), hs, cur_req);
    end
    @(negedge CLK_n);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
